// File: rtl/id_fwd_scoreboard.sv
// ID-stage operand forwarding, long-latency scoreboard and stall/hang monitor for NUM_RD read ports.
// Optional feature macro: ID_EX_FWD_EN (EX-stage non-load results forwarded instead of stalling).
module id_fwd_scoreboard #(
  parameter int NUM_RD  = 2,
  parameter int DW      = 32,
  parameter int NREG    = 32,
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 32,
  localparam int AW     = $clog2(NREG)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_RD-1:0]    ren_i,
  input  logic [NUM_RD*AW-1:0] raddr_i,
  input  logic [NUM_RD*DW-1:0] rdata_i,
  input  logic                 ex_we_i,
  input  logic [AW-1:0]        ex_waddr_i,
  input  logic [DW-1:0]        ex_wdata_i,
  input  logic                 ex_is_load_i,
  input  logic                 mem_we_i,
  input  logic [AW-1:0]        mem_waddr_i,
  input  logic [DW-1:0]        mem_wdata_i,
  input  logic                 wb_we_i,
  input  logic [AW-1:0]        wb_waddr_i,
  input  logic [DW-1:0]        wb_wdata_i,
  input  logic                 lc_we_i,
  input  logic [AW-1:0]        lc_waddr_i,
  input  logic [DW-1:0]        lc_wdata_i,
  input  logic                 issue_i,
  input  logic [AW-1:0]        issue_waddr_i,
  input  logic                 flush_i,
  output logic [NUM_RD*DW-1:0] rdata_o,
  output logic                 stall_o,
  output logic [AW:0]          pending_cnt_o,
  output logic [CNT_W-1:0]     stall_cycles_o,
  output logic                 hang_o
);

  localparam int RW = $clog2(TIMEOUT) + 1;
  localparam logic [RW-1:0] TO_M1 = RW'(TIMEOUT - 1);

  typedef enum logic {RUN, STALL} state_t;

  state_t            state;
  logic [RW-1:0]     run_cnt;
  logic [RW-1:0]     run_step;
  logic [NREG-1:0]   pending;
  logic [NREG-1:0]   pending_nxt;
  logic [AW:0]       cnt_nxt;
  logic [NUM_RD-1:0] port_haz;
  logic              issue_haz;
  logic              stall;
  logic              do_set;

`ifndef ID_EX_FWD_EN
  logic unused_ex;
  assign unused_ex = ^{ex_is_load_i, ex_wdata_i};
`endif

  for (genvar g = 0; g < NUM_RD; g++) begin : g_port
    logic [AW-1:0] a;
    logic          ex_hit, mem_hit, lc_hit, wb_hit;
    logic          ex_fwd, ex_stall;
    logic [DW-1:0] sel;

    assign a       = raddr_i[g*AW +: AW];
    assign ex_hit  = ex_we_i  && (ex_waddr_i  == a);
    assign mem_hit = mem_we_i && (mem_waddr_i == a);
    assign lc_hit  = lc_we_i  && (lc_waddr_i  == a);
    assign wb_hit  = wb_we_i  && (wb_waddr_i  == a);

`ifdef ID_EX_FWD_EN
    assign ex_fwd   = ex_hit && !ex_is_load_i;
    assign ex_stall = ex_hit && ex_is_load_i;
`else
    // Without the EX bypass the value reaches us from MEM one cycle later.
    assign ex_fwd   = 1'b0;
    assign ex_stall = ex_hit;
`endif

    always_comb begin
      if (a == '0)     sel = '0;
      else if (ex_fwd)  sel = ex_wdata_i;
      else if (mem_hit) sel = mem_wdata_i;
      else if (lc_hit)  sel = lc_wdata_i;
      else if (wb_hit)  sel = wb_wdata_i;
      else              sel = rdata_i[g*DW +: DW];
    end

    assign rdata_o[g*DW +: DW] = rst_i ? '0 : sel;
    assign port_haz[g] = ren_i[g] && (a != '0) && (ex_stall || (pending[a] && !lc_hit));
  end

  assign issue_haz = issue_i && !flush_i && pending[issue_waddr_i] &&
                     !(lc_we_i && (lc_waddr_i == issue_waddr_i));
  assign stall     = !rst_i && ((|port_haz) || issue_haz);
  assign stall_o   = stall;
  assign do_set    = issue_i && !flush_i && !stall && (issue_waddr_i != '0);

  // Set is applied after clear so a same-cycle retire/reissue stays pending.
  always_comb begin
    pending_nxt = pending;
    if (lc_we_i) pending_nxt[lc_waddr_i] = 1'b0;
    if (do_set)  pending_nxt[issue_waddr_i] = 1'b1;
    pending_nxt[0] = 1'b0;
  end

  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < NREG; i++) cnt_nxt = cnt_nxt + {{AW{1'b0}}, pending_nxt[i]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending        <= '0;
      pending_cnt_o  <= '0;
      stall_cycles_o <= '0;
    end else begin
      pending       <= pending_nxt;
      pending_cnt_o <= cnt_nxt;
      if (stall && (stall_cycles_o != {CNT_W{1'b1}})) stall_cycles_o <= stall_cycles_o + CNT_W'(1);
    end
  end

  // Length of the current stall run, counting this cycle; saturates at TIMEOUT-1.
  always_comb begin
    if (state == STALL) run_step = (run_cnt == TO_M1) ? run_cnt : run_cnt + RW'(1);
    else                run_step = RW'(1);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= RUN;
      run_cnt <= '0;
      hang_o  <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (stall) begin
            state   <= STALL;
            run_cnt <= run_step;
          end
        end
        STALL: begin
          if (stall) begin
            run_cnt <= run_step;
          end else begin
            state   <= RUN;
            run_cnt <= '0;
          end
        end
        default: begin
          state   <= RUN;
          run_cnt <= '0;
        end
      endcase
      if (stall && (run_step >= TO_M1)) hang_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_id_fwd_scoreboard.sv
// Self-checking bench for id_fwd_scoreboard: directed scenarios plus randomized traffic against a reference model.
module tb_id_fwd_scoreboard;
  localparam int NUM_RD = 2;
  localparam int DW     = 32;
  localparam int NREG   = 32;
  localparam int AW     = 5;
  localparam int TO     = 4;
  localparam int CNT_W  = 32;

  logic                 clk_i, rst_i;
  logic [NUM_RD-1:0]    ren_i;
  logic [NUM_RD*AW-1:0] raddr_i;
  logic [NUM_RD*DW-1:0] rdata_i;
  logic                 ex_we_i, ex_is_load_i, mem_we_i, wb_we_i, lc_we_i, issue_i, flush_i;
  logic [AW-1:0]        ex_waddr_i, mem_waddr_i, wb_waddr_i, lc_waddr_i, issue_waddr_i;
  logic [DW-1:0]        ex_wdata_i, mem_wdata_i, wb_wdata_i, lc_wdata_i;
  logic [NUM_RD*DW-1:0] rdata_o;
  logic                 stall_o, hang_o;
  logic [AW:0]          pending_cnt_o;
  logic [CNT_W-1:0]     stall_cycles_o;

  int chk = 0;
  int err = 0;

  // Reference model state
  bit [NREG-1:0]  mpend;
  int             mrun;
  bit             mhang;
  logic [CNT_W-1:0] mstallcyc;

  id_fwd_scoreboard #(.NUM_RD(NUM_RD), .DW(DW), .NREG(NREG), .TIMEOUT(TO), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .ren_i(ren_i), .raddr_i(raddr_i), .rdata_i(rdata_i),
    .ex_we_i(ex_we_i), .ex_waddr_i(ex_waddr_i), .ex_wdata_i(ex_wdata_i), .ex_is_load_i(ex_is_load_i),
    .mem_we_i(mem_we_i), .mem_waddr_i(mem_waddr_i), .mem_wdata_i(mem_wdata_i),
    .wb_we_i(wb_we_i), .wb_waddr_i(wb_waddr_i), .wb_wdata_i(wb_wdata_i),
    .lc_we_i(lc_we_i), .lc_waddr_i(lc_waddr_i), .lc_wdata_i(lc_wdata_i),
    .issue_i(issue_i), .issue_waddr_i(issue_waddr_i), .flush_i(flush_i),
    .rdata_o(rdata_o), .stall_o(stall_o), .pending_cnt_o(pending_cnt_o),
    .stall_cycles_o(stall_cycles_o), .hang_o(hang_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  function automatic logic [DW-1:0] model_rdata(input int p);
    logic [AW-1:0] a;
    a = raddr_i[p*AW +: AW];
    if (rst_i) return '0;
    if (a == 0) return '0;
`ifdef ID_EX_FWD_EN
    if (ex_we_i && ex_waddr_i == a && !ex_is_load_i) return ex_wdata_i;
`endif
    if (mem_we_i && mem_waddr_i == a) return mem_wdata_i;
    if (lc_we_i && lc_waddr_i == a) return lc_wdata_i;
    if (wb_we_i && wb_waddr_i == a) return wb_wdata_i;
    return rdata_i[p*DW +: DW];
  endfunction

  function automatic bit model_stall();
    logic [AW-1:0] a;
    bit fwd_en;
`ifdef ID_EX_FWD_EN
    fwd_en = 1'b1;
`else
    fwd_en = 1'b0;
`endif
    if (rst_i) return 1'b0;
    for (int p = 0; p < NUM_RD; p++) begin
      a = raddr_i[p*AW +: AW];
      if (ren_i[p] && a != 0) begin
        if (ex_we_i && ex_waddr_i == a && (ex_is_load_i || !fwd_en)) return 1'b1;
        if (mpend[a] && !(lc_we_i && lc_waddr_i == a)) return 1'b1;
      end
    end
    if (issue_i && !flush_i && mpend[issue_waddr_i] && !(lc_we_i && lc_waddr_i == issue_waddr_i))
      return 1'b1;
    return 1'b0;
  endfunction

  task automatic idle();
    ren_i = '0; raddr_i = '0; rdata_i = {$urandom, $urandom};
    ex_we_i = 0; ex_is_load_i = 0; mem_we_i = 0; wb_we_i = 0; lc_we_i = 0;
    issue_i = 0; flush_i = 0;
    ex_waddr_i = '0; mem_waddr_i = '0; wb_waddr_i = '0; lc_waddr_i = '0; issue_waddr_i = '0;
    ex_wdata_i = '0; mem_wdata_i = '0; wb_wdata_i = '0; lc_wdata_i = '0;
  endtask

  task automatic model_clear();
    mpend = '0; mrun = 0; mhang = 0; mstallcyc = '0;
  endtask

  // Advance the model with the inputs currently applied, then clock the DUT.
  task automatic tick();
    bit s;
    s = model_stall();
    if (!rst_i) begin
      if (lc_we_i) mpend[lc_waddr_i] = 1'b0;
      if (issue_i && !flush_i && !s && issue_waddr_i != 0) mpend[issue_waddr_i] = 1'b1;
      if (s && mstallcyc != {CNT_W{1'b1}}) mstallcyc = mstallcyc + 1;
      mrun = s ? mrun + 1 : 0;
      if (mrun >= TO - 1) mhang = 1'b1;
    end else begin
      model_clear();
    end
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    idle();
    model_clear();
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    idle();
    model_clear();
    ren_i = 2'b11; raddr_i[0 +: AW] = 5; ex_we_i = 1; ex_waddr_i = 5; ex_is_load_i = 1;
    rdata_i = {32'h5555_0000, 32'h0000_AAAA};
    #1;
    chk++; if (rdata_o !== '0) begin err++; $display("FAIL reset_rdata got %h want 0", rdata_o); end
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL reset_stall got %b want 0", stall_o); end
    @(posedge clk_i); @(negedge clk_i);
    #1;
    chk++; if (pending_cnt_o !== '0 || stall_cycles_o !== '0 || hang_o !== 1'b0) begin
      err++; $display("FAIL reset_state got cnt=%0d cyc=%0d hang=%b want 0/0/0", pending_cnt_o, stall_cycles_o, hang_o);
    end
    rst_i = 1'b0;
    idle();
  endtask

  task automatic test_ex_fwd();
    idle();
    ren_i = 2'b01; raddr_i[0 +: AW] = 5; rdata_i[0 +: DW] = 32'h1111;
    ex_we_i = 1; ex_waddr_i = 5; ex_wdata_i = 32'hA5; ex_is_load_i = 0;
    #1;
`ifdef ID_EX_FWD_EN
    chk++; if (rdata_o[0 +: DW] !== 32'hA5) begin err++; $display("FAIL ex_fwd_data got %h want a5", rdata_o[0 +: DW]); end
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL ex_fwd_stall got %b want 0", stall_o); end
`else
    chk++; if (stall_o !== 1'b1) begin err++; $display("FAIL ex_nofwd_stall got %b want 1", stall_o); end
    chk++; if (rdata_o[0 +: DW] !== 32'h1111) begin err++; $display("FAIL ex_nofwd_data got %h want 1111", rdata_o[0 +: DW]); end
`endif
    tick();
    idle();
    tick();
  endtask

  task automatic test_load_use();
    idle();
    ren_i = 2'b10; raddr_i[AW +: AW] = 7; rdata_i[DW +: DW] = 32'hDEAD;
    ex_we_i = 1; ex_waddr_i = 7; ex_is_load_i = 1; ex_wdata_i = 32'h9999;
    #1;
    chk++; if (stall_o !== 1'b1) begin err++; $display("FAIL load_use_stall got %b want 1", stall_o); end
    tick();
    ex_we_i = 0; ex_is_load_i = 0;
    mem_we_i = 1; mem_waddr_i = 7; mem_wdata_i = 32'h1234;
    #1;
    chk++; if (rdata_o[DW +: DW] !== 32'h1234) begin err++; $display("FAIL load_use_mem got %h want 1234", rdata_o[DW +: DW]); end
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL load_use_release got %b want 0", stall_o); end
    tick();
    idle();
  endtask

  task automatic test_priority();
    idle();
    ren_i = 2'b01; raddr_i[0 +: AW] = 3;
    mem_we_i = 1; mem_waddr_i = 3; mem_wdata_i = 11;
    lc_we_i  = 1; lc_waddr_i  = 3; lc_wdata_i  = 22;
    wb_we_i  = 1; wb_waddr_i  = 3; wb_wdata_i  = 33;
    #1;
    chk++; if (rdata_o[0 +: DW] !== 32'd11) begin err++; $display("FAIL prio_mem got %0d want 11", rdata_o[0 +: DW]); end
    tick();
    mem_we_i = 0;
    #1;
    chk++; if (rdata_o[0 +: DW] !== 32'd22) begin err++; $display("FAIL prio_lc got %0d want 22", rdata_o[0 +: DW]); end
    tick();
    idle();
    ren_i = 2'b11; raddr_i = '0; rdata_i = {32'h7777, 32'h8888};
    ex_we_i = 1; ex_waddr_i = 0; ex_is_load_i = 1; ex_wdata_i = 44;
    mem_we_i = 1; mem_waddr_i = 0; mem_wdata_i = 11;
    lc_we_i  = 1; lc_waddr_i  = 0; lc_wdata_i  = 22;
    wb_we_i  = 1; wb_waddr_i  = 0; wb_wdata_i  = 33;
    #1;
    chk++; if (rdata_o !== '0) begin err++; $display("FAIL r0_data got %h want 0", rdata_o); end
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL r0_stall got %b want 0", stall_o); end
    tick();
    idle();
  endtask

  task automatic test_scoreboard();
    idle();
    issue_i = 1; issue_waddr_i = 9;
    tick();
    idle();
    #1;
    chk++; if (pending_cnt_o !== 6'd1) begin err++; $display("FAIL sb_cnt_set got %0d want 1", pending_cnt_o); end
    ren_i = 2'b01; raddr_i[0 +: AW] = 9;
    for (int k = 0; k < 2; k++) begin
      #1;
      chk++; if (stall_o !== 1'b1) begin err++; $display("FAIL sb_stall got %b want 1", stall_o); end
      tick();
    end
    lc_we_i = 1; lc_waddr_i = 9; lc_wdata_i = 32'hBEEF;
    #1;
    chk++; if (rdata_o[0 +: DW] !== 32'hBEEF) begin err++; $display("FAIL sb_lc_data got %h want beef", rdata_o[0 +: DW]); end
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL sb_lc_release got %b want 0", stall_o); end
    tick();
    idle();
    #1;
    chk++; if (pending_cnt_o !== 6'd0) begin err++; $display("FAIL sb_cnt_clr got %0d want 0", pending_cnt_o); end
    chk++; if (stall_cycles_o !== mstallcyc) begin err++; $display("FAIL sb_stall_cycles got %0d want %0d", stall_cycles_o, mstallcyc); end
  endtask

  task automatic test_waw();
    idle();
    issue_i = 1; issue_waddr_i = 9;
    tick();
    issue_i = 1; issue_waddr_i = 9;
    #1;
    chk++; if (stall_o !== 1'b1) begin err++; $display("FAIL waw_stall got %b want 1", stall_o); end
    tick();
    idle();
    ren_i = 2'b01; raddr_i[0 +: AW] = 9; issue_i = 1; issue_waddr_i = 12;
    tick();
    idle();
    #1;
    chk++; if (pending_cnt_o !== 6'd1) begin err++; $display("FAIL stalled_issue_blocked got %0d want 1", pending_cnt_o); end
    issue_i = 1; issue_waddr_i = 9; lc_we_i = 1; lc_waddr_i = 9;
    #1;
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL same_cycle_issue got %b want 0", stall_o); end
    tick();
    idle();
    ren_i = 2'b01; raddr_i[0 +: AW] = 9;
    #1;
    chk++; if (pending_cnt_o !== 6'd1 || stall_o !== 1'b1) begin
      err++; $display("FAIL set_wins got cnt=%0d stall=%b want 1/1", pending_cnt_o, stall_o);
    end
    tick();
    idle();
    issue_i = 1; issue_waddr_i = 9; flush_i = 1;
    #1;
    chk++; if (stall_o !== 1'b0) begin err++; $display("FAIL flush_no_waw got %b want 0", stall_o); end
    tick();
    issue_i = 1; issue_waddr_i = 10; flush_i = 1; lc_we_i = 1; lc_waddr_i = 9;
    tick();
    idle();
    #1;
    chk++; if (pending_cnt_o !== 6'd0) begin err++; $display("FAIL flush_ignored got %0d want 0", pending_cnt_o); end
  endtask

  task automatic test_hang();
    do_reset();
    issue_i = 1; issue_waddr_i = 6;
    tick();
    idle();
    ren_i = 2'b01; raddr_i[0 +: AW] = 6; rdata_i[0 +: DW] = 32'h4242;
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk++; if (stall_o !== 1'b1 || hang_o !== (k >= 4)) begin
        err++; $display("FAIL hang_cycle%0d got stall=%b hang=%b want 1/%b", k, stall_o, hang_o, (k >= 4));
      end
      tick();
    end
    #1;
    chk++; if (stall_cycles_o !== 32'd6 || hang_o !== 1'b1) begin
      err++; $display("FAIL hang_total got cyc=%0d hang=%b want 6/1", stall_cycles_o, hang_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    chk++; if (rdata_o !== '0 || stall_o !== 1'b0 || pending_cnt_o !== '0 || stall_cycles_o !== '0 || hang_o !== 1'b0) begin
      err++; $display("FAIL async_reset got rd=%h st=%b cnt=%0d cyc=%0d hang=%b want all 0",
                      rdata_o, stall_o, pending_cnt_o, stall_cycles_o, hang_o);
    end
    lc_we_i = 1; lc_waddr_i = 6; lc_wdata_i = 32'hCAFE;
    tick();
    rst_i = 1'b0;
    #1;
    chk++; if (stall_o !== 1'b0 || rdata_o[0 +: DW] !== 32'hCAFE) begin
      err++; $display("FAIL post_reset_lc got stall=%b rd=%h want 0/cafe", stall_o, rdata_o[0 +: DW]);
    end
    tick();
    idle();
    #1;
    chk++; if (pending_cnt_o !== '0) begin err++; $display("FAIL post_reset_cnt got %0d want 0", pending_cnt_o); end
  endtask

  task automatic test_random();
    logic [DW-1:0] exp0, exp1;
    bit es;
    for (int n = 0; n < 300; n++) begin
      ren_i = NUM_RD'($urandom);
      for (int p = 0; p < NUM_RD; p++) raddr_i[p*AW +: AW] = AW'($urandom_range(0, 7));
      rdata_i = {$urandom, $urandom};
      ex_we_i = 1'($urandom); ex_waddr_i = AW'($urandom_range(0, 7)); ex_wdata_i = $urandom;
      ex_is_load_i = 1'($urandom);
      mem_we_i = 1'($urandom); mem_waddr_i = AW'($urandom_range(0, 7)); mem_wdata_i = $urandom;
      wb_we_i = 1'($urandom); wb_waddr_i = AW'($urandom_range(0, 7)); wb_wdata_i = $urandom;
      lc_we_i = ($urandom_range(0, 2) == 0); lc_waddr_i = AW'($urandom_range(0, 7)); lc_wdata_i = $urandom;
      issue_i = ($urandom_range(0, 3) == 0); issue_waddr_i = AW'($urandom_range(0, 7));
      flush_i = ($urandom_range(0, 7) == 0);
      #1;
      exp0 = model_rdata(0);
      exp1 = model_rdata(1);
      es = model_stall();
      chk++; if (rdata_o[0 +: DW] !== exp0) begin err++; $display("FAIL rnd%0d_rdata0 got %h want %h", n, rdata_o[0 +: DW], exp0); end
      chk++; if (rdata_o[DW +: DW] !== exp1) begin err++; $display("FAIL rnd%0d_rdata1 got %h want %h", n, rdata_o[DW +: DW], exp1); end
      chk++; if (stall_o !== es) begin err++; $display("FAIL rnd%0d_stall got %b want %b", n, stall_o, es); end
      chk++; if (pending_cnt_o !== ($countones(mpend))) begin
        err++; $display("FAIL rnd%0d_cnt got %0d want %0d", n, pending_cnt_o, $countones(mpend));
      end
      chk++; if (stall_cycles_o !== mstallcyc || hang_o !== mhang) begin
        err++; $display("FAIL rnd%0d_counters got cyc=%0d hang=%b want %0d/%b", n, stall_cycles_o, hang_o, mstallcyc, mhang);
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst_i = 1'b1;
    idle();
    model_clear();
    test_reset();
    @(negedge clk_i);
    test_ex_fwd();
    test_load_use();
    test_priority();
    test_scoreboard();
    test_waw();
    test_hang();
    test_random();
    $display("CHECKS %0d ERRORS %0d", chk, err);
    $finish;
  end

endmodule
